// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory bus (cyc/stb/we/ack).
// Latency: grant 1 cycle after cyc is sampled; the granted bus path is combinational, and a handoff has no dead cycle.
// Backpressure: the owner holds the bus while its cyc is high. The other master waits.
// The stuck-slave watchdog and ABORT state are built only when MEM_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

`ifdef MEM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t state, state_nxt;
    logic   last_owner, last_owner_nxt;   // 0 = M0, 1 = M1

    // On a tie, the master that did not own the bus last wins.
    function automatic state_t pick(input logic c0, input logic c1, input logic last);
        if (c0 && c1)
            return last ? OWN0 : OWN1;
        else if (c0)
            return OWN0;
        else if (c1)
            return OWN1;
        else
            return IDLE;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    logic          wd_wait;
    logic          to_hit;

    assign wd_wait = ((state == OWN0) || (state == OWN1)) && s_stb_o && !s_ack_i;
    // Abort on the edge that closes the TO_CYCLES-th unanswered strobe cycle.
    assign to_hit  = wd_wait && (wd_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if ((state_nxt != state) || s_ack_i)
            wd_cnt <= '0;
        else if (wd_wait)
            wd_cnt <= wd_cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: state_nxt = pick(m0_cyc_i, m1_cyc_i, last_owner);
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_owner_nxt = 1'b0;
                    state_nxt      = m1_cyc_i ? OWN1 : IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    last_owner_nxt = 1'b0;
                    state_nxt      = ABORT;
                end
`endif
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_owner_nxt = 1'b1;
                    state_nxt      = m0_cyc_i ? OWN0 : IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    last_owner_nxt = 1'b1;
                    state_nxt      = ABORT;
                end
`endif
            end
`ifdef MEM_ARB_TIMEOUT_EN
            ABORT: state_nxt = pick(m0_cyc_i, m1_cyc_i, last_owner);
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Routing follows the current state, so an ack coinciding with a cyc drop still reaches the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & m0_cyc_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                gnt_o    = 2'b01;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & m1_cyc_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    assign m0_err_o = (state == ABORT) && !last_owner;
    assign m1_err_o = (state == ABORT) &&  last_owner;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed master stimulus, a behavioural slave and a scoreboard monitor.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [7:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [7:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic       s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0] gnt_o;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TO_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_wr_q[$];
    logic [7:0]  mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_lat  = 1;
    bit          slave_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive(input bit id, input logic cyc, input logic stb, input logic we,
                         input logic [7:0] adr, input logic [7:0] dat);
        if (id) begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
        end else begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
        end
    endtask

    // Present one beat and wait (bounded) for the master's ack; returns on the sampling edge of the ack.
    task automatic beat(input bit id, input logic we, input logic [7:0] adr, input logic [7:0] dat);
        bit got = 1'b0;
        drive(id, 1'b1, 1'b1, we, adr, dat);
        for (int k = 0; k < 20 && !got; k++) begin
            smp;
            if (id ? m1_ack_o : m0_ack_o) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL beat_ack: master %0d adr %0h got no ack in 20 cycles, expected an ack", id, adr);
        end
    endtask

    task automatic do_reset;
        drive(1'b0, 0, 0, 0, 8'h00, 8'h00);
        drive(1'b1, 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Slave: acks after ack_lat unanswered strobe cycles, holds ack for one cycle.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                s_ack_i = 1'b0; s_dat_i = 8'h00; wcnt = 0;
            end else if (s_ack_i) begin
                s_ack_i = 1'b0; s_dat_i = 8'h00; wcnt = 0;
            end else if (slave_en && s_cyc_o && s_stb_o) begin
                if (wcnt == ack_lat) begin
                    s_ack_i = 1'b1;
                    if (s_we_o) mem[s_adr_o] = s_dat_o;
                    else        s_dat_i = mem[s_adr_o];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor: every master ack and every slave-side write beat is popped and compared.
    initial begin
        exp_t        e;
        logic [15:0] w;
        forever begin
            smp;
            if (rst === 1'b1) begin
                if (m0_ack_o || m1_ack_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, expected no ack", m0_ack_o, m1_ack_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_owner", {m1_ack_o, m0_ack_o}, e.id ? 2'b10 : 2'b01);
                        chk("ack_dat", e.id ? m1_dat_o : m0_dat_o, e.dat);
                        chk("nonowner_dat", e.id ? m0_dat_o : m1_dat_o, 0);
                    end
                end
                if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_write: adr %0h dat %0h, expected none", s_adr_o, s_dat_o);
                    end else begin
                        w = exp_wr_q.pop_front();
                        chk("wr_beat", {s_adr_o, s_dat_o}, w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "bench timeout");
    end

    localparam bit WIN [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b0; s_ack_i = 1'b0; s_dat_i = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA5;

        // Reset values, then single M0 read acked two cycles after the request
        do_reset;
        smp;
        chk("rst_ctrl", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o}, 0);
        chk("rst_data", {s_adr_o, s_dat_o, m0_dat_o, m1_dat_o}, 0);
        nxt; drive(1'b0, 1, 1, 0, 8'h10, 8'h00); exp_q.push_back('{1'b0, 8'hA5});
        smp; chk("t1_gnt_req_cycle", gnt_o, 2'b00);
        nxt; smp; chk("t1_gnt", gnt_o, 2'b01); chk("t1_s_adr", s_adr_o, 8'h10);
        chk("t1_s_stb_we", {s_cyc_o, s_stb_o, s_we_o}, 3'b110);
        nxt; smp; chk("t1_m0_ack", m0_ack_o, 1'b1); chk("t1_m1_ack", m1_ack_o, 1'b0);
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp; chk("t1_gnt_drop_cycle", gnt_o, 2'b01);
        nxt; smp; chk("t1_gnt_idle", gnt_o, 2'b00);

        // Simultaneous requests after reset: M0 first, then direct handoff to M1
        do_reset;
        nxt; drive(1'b0, 1, 1, 0, 8'h30, 8'h00); drive(1'b1, 1, 1, 0, 8'h31, 8'h00);
        exp_q.push_back('{1'b0, 8'h30 ^ 8'h5A}); exp_q.push_back('{1'b1, 8'h31 ^ 8'h5A});
        smp; chk("t2_gnt_req_cycle", gnt_o, 2'b00);
        nxt; smp; chk("t2_first_m0", gnt_o, 2'b01);
        nxt; smp;
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp; chk("t2_hold", gnt_o, 2'b01);
        nxt; smp; chk("t2_handoff_no_gap", gnt_o, 2'b10);
        nxt; smp;
        nxt; drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp;
        nxt; smp; chk("t2_idle", gnt_o, 2'b00);

        // Lone M0 read leaves M0 as last owner; repeated ties then go M1, M0, M1
        nxt; exp_q.push_back('{1'b0, 8'h32 ^ 8'h5A}); beat(1'b0, 0, 8'h32, 8'h00);
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp;
        for (int r = 0; r < 3; r++) begin
            nxt;
            drive(1'b0, 1, 1, 0, 8'h50 + 8'(r), 8'h00);
            drive(1'b1, 1, 1, 0, 8'h60 + 8'(r), 8'h00);
            exp_q.push_back('{WIN[r], (WIN[r] ? 8'h60 : 8'h50) + 8'(r) ^ 8'h5A});
            smp;
            nxt; smp; chk("t2_rr_winner", gnt_o, WIN[r] ? 2'b10 : 2'b01);
            nxt; smp;
            nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp;
            nxt; smp; chk("t2_rr_idle", gnt_o, 2'b00);
        end

        // M1 locked 4-beat write burst while M0 requests throughout
        ack_lat = 0;
        for (int i = 0; i < 4; i++) begin
            exp_wr_q.push_back({8'h20 + 8'(i), 8'h01 + 8'(i)});
            exp_q.push_back('{1'b1, 8'h00});
        end
        exp_q.push_back('{1'b0, 8'h40 ^ 8'h5A});
        nxt; drive(1'b1, 1, 1, 1, 8'h20, 8'h01); smp;
        nxt; drive(1'b0, 1, 1, 0, 8'h40, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt;
            beat(1'b1, 1, 8'h20 + 8'(i), 8'h01 + 8'(i));
            chk("t3_burst_gnt", gnt_o, 2'b10);
        end
        nxt; drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp; chk("t3_hold_after_drop", gnt_o, 2'b10);
        nxt; smp; chk("t3_m0_after_burst", gnt_o, 2'b01);
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp;
        nxt;

        // Asynchronous reset in the middle of an M1 cycle
        slave_en = 1'b0;
        drive(1'b1, 1, 1, 0, 8'h70, 8'h00); smp;
        nxt; smp; chk("t4_own1", {gnt_o, s_stb_o}, 3'b101);
        #2 rst = 1'b0;
        #1 chk("t4_async_clear", {s_cyc_o, s_stb_o, gnt_o}, 4'b0000);
        @(posedge clk); #1;
        drive(1'b0, 1, 1, 0, 8'h71, 8'h00); rst = 1'b1;
        smp; chk("t4_idle_after_release", gnt_o, 2'b00);
        nxt; smp; chk("t4_m0_wins_tie", gnt_o, 2'b01);
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp;

        // Slave that never acks an M0 read, with M1 pending
        do_reset;
        nxt; drive(1'b0, 1, 1, 0, 8'h80, 8'h00); smp;
        nxt; drive(1'b1, 1, 1, 0, 8'h81, 8'h00); smp;
        chk("t5_wait_1", {m1_err_o, m0_err_o, gnt_o}, 4'b0001);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            nxt; smp; chk("t5_wait", {m1_err_o, m0_err_o, gnt_o}, 4'b0001);
        end
        nxt; smp; chk("t5_abort", {m1_err_o, m0_err_o, s_cyc_o, gnt_o}, 5'b01000);
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp;
        chk("t5_m1_after_abort", {m1_err_o, m0_err_o, gnt_o}, 4'b0010);
        nxt; drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp;
`else
        for (int c = 0; c < 100; c++) begin
            nxt; smp; chk("t5_stuck_hold", {m1_err_o, m0_err_o, gnt_o}, 4'b0001);
        end
        nxt; drive(1'b0, 0, 0, 0, 8'h00, 8'h00); smp; chk("t5_drop_cycle", gnt_o, 2'b01);
        nxt; smp; chk("t5_m1_after_drop", gnt_o, 2'b10);
        nxt; drive(1'b1, 0, 0, 0, 8'h00, 8'h00); smp;
`endif

        repeat (3) nxt;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_wr_q_drained", exp_wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
